demux_1xn_lane_striper: RTL and testbench



---
 rtl/demux_1xn_lane_striper_pkg.sv | 26 ++
 rtl/demux_1xn_lane_striper_if.sv | 37 +++
 rtl/demux_1xn_lane_striper_lane_fifo.sv | 69 ++++++
 rtl/demux_1xn_lane_striper.sv | 77 +++++++
 tb/tb_demux_1xn_lane_striper.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_1xn_lane_striper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_pkg
// Description : Default sizes, lane index type and width helpers for the
//               round-robin lane striper.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_LANES  = 4;
    localparam int c_DEPTH  = 4;

    typedef logic [$clog2(c_LANES)-1:0] lane_idx_t;

    // Keeps the pointer at least one bit wide even for degenerate lane counts
    function automatic int ptr_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1xn_lane_striper_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1xn_lane_striper_if
// Description : Byte-stream input and per-lane output bundle of the striper.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1xn_lane_striper_if
    import lane_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LANES  = c_LANES,
    parameter int DEPTH  = c_DEPTH
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_sop;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_valid;
    logic [LANES-1:0]        out_ready;
    logic [LANES*CNT_W-1:0]  lane_level;

    modport master (
        output in_data, in_valid, in_sop, out_ready,
        input  in_ready, out_data, out_valid, lane_level
    );

    modport slave (
        input  in_data, in_valid, in_sop, out_ready,
        output in_ready, out_data, out_valid, lane_level
    );

endinterface
`default_nettype wire

// File: rtl/demux_1xn_lane_striper_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo
// Description : Synchronous first-word-fall-through FIFO for one output lane.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo
    import lane_pkg::*;
#(
    parameter  int DATA_W = c_DATA_W,
    parameter  int DEPTH  = c_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    output logic                   full,
    input  wire logic              pop,
    output logic [DATA_W-1:0]      head_data,
    output logic                   empty,
    output logic [CNT_W-1:0]       level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign full      = (r_level == CNT_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    // Stale storage is never exposed: an empty lane shows zero data
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_1xn_lane_striper.sv
`default_nettype none
// ============================================================================
// Module      : demux_1xn_lane_striper
// Description : Stripes one symbol stream round-robin over LANES lane FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1xn_lane_striper
    import lane_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LANES  = c_LANES,
    parameter int DEPTH  = c_DEPTH
) (
    input  wire logic                clk,
    input  wire logic                reset,
    demux_1xn_lane_striper_if.slave  bus
);

    localparam int PTR_W = ptr_width(LANES);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST_LANE = PTR_W'(LANES - 1);

    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_tgt;
    logic                    w_in_ready;
    logic                    w_accept;
    logic [LANES-1:0]        w_full;
    logic [LANES-1:0]        w_empty;
    logic [LANES-1:0]        w_push;
    logic [LANES-1:0]        w_pop;
    logic [LANES*DATA_W-1:0] w_out_data;
    logic [LANES*CNT_W-1:0]  w_level;

    assign w_tgt = bus.in_sop ? '0 : r_ptr;
    // Ready looks only at stored occupancy, so a full lane never passes through
    assign w_in_ready = ~reset & ~w_full[w_tgt];
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = ~w_empty;
    assign bus.out_data   = w_out_data;
    assign bus.lane_level = w_level;

    // Explicit compare-and-wrap so non power-of-2 lane counts work
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_tgt == c_LAST_LANE) ? '0 : w_tgt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_push[gi] = w_accept & (w_tgt == PTR_W'(gi));
            assign w_pop[gi]  = bus.out_ready[gi] & ~w_empty[gi];

            lane_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (w_push[gi]),
                .push_data (bus.in_data),
                .full      (w_full[gi]),
                .pop       (w_pop[gi]),
                .head_data (w_out_data[gi*DATA_W +: DATA_W]),
                .empty     (w_empty[gi]),
                .level     (w_level[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_1xn_lane_striper.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1xn_lane_striper
// Description : Scoreboard bench for a 4x4x8 and a 3x2x16 lane striper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1xn_lane_striper;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    demux_1xn_lane_striper_if #(.DATA_W(8),  .LANES(4), .DEPTH(4)) bus_a ();
    demux_1xn_lane_striper_if #(.DATA_W(16), .LANES(3), .DEPTH(2)) bus_b ();

    demux_1xn_lane_striper #(.DATA_W(8), .LANES(4), .DEPTH(4)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    demux_1xn_lane_striper #(.DATA_W(16), .LANES(3), .DEPTH(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_err = 0;
    int n_chk = 0;

    // Expected lane contents and round-robin pointer per DUT
    int unsigned mq [2][4][$];
    int          mptr [2];
    logic        acc [2];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_dut(input int d);
        logic        rdy, iv, isop, exp_rdy;
        logic [3:0]  ov, ordy;
        logic [15:0] idata;
        logic [15:0] od [4];
        int          lv [4];
        int          nl, dp, tgt;
        nl = (d == 0) ? 4 : 3;
        dp = (d == 0) ? 4 : 2;
        ov = '0;
        ordy = '0;
        if (d == 0) begin
            rdy = bus_a.in_ready; iv = bus_a.in_valid; isop = bus_a.in_sop;
            idata = 16'(bus_a.in_data);
            for (int l = 0; l < 4; l++) begin
                ov[l] = bus_a.out_valid[l]; ordy[l] = bus_a.out_ready[l];
                od[l] = 16'(bus_a.out_data[l*8 +: 8]);
                lv[l] = int'(bus_a.lane_level[l*3 +: 3]);
            end
        end else begin
            rdy = bus_b.in_ready; iv = bus_b.in_valid; isop = bus_b.in_sop;
            idata = bus_b.in_data;
            for (int l = 0; l < 3; l++) begin
                ov[l] = bus_b.out_valid[l]; ordy[l] = bus_b.out_ready[l];
                od[l] = bus_b.out_data[l*16 +: 16];
                lv[l] = int'(bus_b.lane_level[l*2 +: 2]);
            end
        end
        tgt = isop ? 0 : mptr[d];
        exp_rdy = !reset && (mq[d][tgt].size() < dp);
        check_eq($sformatf("d%0d in_ready", d), 64'(rdy), 64'(exp_rdy));
        for (int l = 0; l < nl; l++) begin
            check_eq($sformatf("d%0d out_valid[%0d]", d, l), 64'(ov[l]), 64'(mq[d][l].size() > 0));
            check_eq($sformatf("d%0d lane_level[%0d]", d, l), 64'(lv[l]), 64'(mq[d][l].size()));
            if (mq[d][l].size() > 0)
                check_eq($sformatf("d%0d out_data[%0d]", d, l), 64'(od[l]), 64'(mq[d][l][0]));
            else
                check_eq($sformatf("d%0d out_data[%0d] idle", d, l), 64'(od[l]), 64'h0);
        end
        acc[d] = 1'b0;
        if (reset) begin
            for (int l = 0; l < 4; l++) mq[d][l].delete();
            mptr[d] = 0;
        end else begin
            for (int l = 0; l < nl; l++)
                if (mq[d][l].size() > 0 && ordy[l]) void'(mq[d][l].pop_front());
            if (iv && exp_rdy) begin
                mq[d][tgt].push_back(int'(idata));
                mptr[d] = (tgt == nl - 1) ? 0 : tgt + 1;
                acc[d] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [15:0] dat, input logic sop);
        if (d == 0) begin
            bus_a.in_valid = v; bus_a.in_data = dat[7:0]; bus_a.in_sop = sop;
        end else begin
            bus_b.in_valid = v; bus_b.in_data = dat; bus_b.in_sop = sop;
        end
    endtask

    task automatic send(input int d, input logic [15:0] dat, input logic sop);
        int n;
        n = 0;
        drive(d, 1'b1, dat, sop);
        acc[d] = 1'b0;
        while (!acc[d] && n < 64) begin
            step();
            n++;
        end
        if (!acc[d]) check_eq($sformatf("d%0d send timeout", d), 64'h0, 64'h1);
        drive(d, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        bus_a.out_ready = 4'hf;
        bus_b.out_ready = 3'h0;
        for (int d = 0; d < 2; d++) mptr[d] = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(1);
        reset = 1'b0;
        idle(1);

        // Straight striping, all lanes draining
        for (int b = 0; b < 8; b++) send(0, 16'(8'h10 + b), 1'b0);
        idle(3);

        // Backpressure: fill everything, 17th byte stalls on lane 0
        bus_a.out_ready = 4'h0;
        for (int b = 0; b < 16; b++) send(0, 16'(8'h20 + b), 1'b0);
        drive(0, 1'b1, 16'h30, 1'b0);
        idle(3);
        check_eq("t2 byte17 held", 64'(acc[0]), 64'h0);
        bus_a.out_ready = 4'h1;
        step();
        check_eq("t2 no pass-through", 64'(acc[0]), 64'h0);
        step();
        check_eq("t2 byte17 accepted", 64'(acc[0]), 64'h1);
        drive(0, 1'b0, 16'h0, 1'b0);
        bus_a.out_ready = 4'hf;
        send(0, 16'h31, 1'b0);
        send(0, 16'h32, 1'b0);
        idle(6);

        // Start-of-packet realignment
        send(0, 16'hA0, 1'b1);
        send(0, 16'hA1, 1'b0);
        send(0, 16'hA2, 1'b1);
        send(0, 16'hA3, 1'b0);
        drive(0, 1'b0, 16'hEE, 1'b1);
        idle(2);
        send(0, 16'hA4, 1'b0);
        idle(2);

        // Full lane 0 with same-cycle pop
        bus_a.out_ready = 4'h0;
        for (int b = 0; b < 4; b++) send(0, 16'(8'hC0 + b), 1'b1);
        drive(0, 1'b1, 16'hC4, 1'b1);
        bus_a.out_ready = 4'h1;
        step();
        check_eq("t4 blocked on full", 64'(acc[0]), 64'h0);
        bus_a.out_ready = 4'h0;
        step();
        check_eq("t4 accepted next", 64'(acc[0]), 64'h1);
        drive(0, 1'b0, 16'h0, 1'b0);
        idle(1);
        bus_a.out_ready = 4'hf;
        idle(3);

        // Mid-stream reset discards buffered symbols
        bus_a.out_ready = 4'h0;
        send(0, 16'h50, 1'b1);
        for (int b = 1; b < 6; b++) send(0, 16'(8'h50 + b), 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        bus_a.out_ready = 4'hf;
        send(0, 16'h60, 1'b0);
        idle(2);

        // Three-lane, two-deep, 16-bit instance
        for (int b = 0; b < 6; b++) send(1, 16'h0100 + 16'(b), 1'b0);
        idle(2);
        bus_b.out_ready = 3'h7;
        idle(4);

        for (int d = 0; d < 2; d++)
            for (int l = 0; l < 4; l++)
                check_eq($sformatf("d%0d lane%0d drained", d, l), 64'(mq[d][l].size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
